inst_dispatcher: RTL and testbench

INST_DISPATCHER -- requirements
Module: inst_dispatcher

---
 rtl/inst_dispatcher_pkg.sv | 41 ++++
 rtl/inst_dispatcher.sv | 149 ++++++++++++++
 tb/tb_inst_dispatcher.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_dispatcher_pkg.sv
// Shared instruction definitions for the systolic-array controller.
// Holds the instruction word geometry (opcode in the MSBs, then ADDRA, then
// ADDRB in the LSBs), the opcode map, and the dispatcher state encoding.
package inst_dispatcher_pkg;

   localparam int OPCODE_BITS = 4;
   localparam int ADDR_BITS   = 16;
   localparam int INST_BITS   = OPCODE_BITS + 2*ADDR_BITS;

   // field positions within the instruction word
   localparam int ADDRB_LSB  = 0;
   localparam int ADDRA_LSB  = ADDR_BITS;
   localparam int OPCODE_LSB = 2*ADDR_BITS;
   localparam int OPCODE_MSB = INST_BITS - 1;

   typedef enum logic [OPCODE_BITS-1:0] {
      OP_IDLE              = 4'd0,
      OP_AXI_TO_UB         = 4'd1,
      OP_UB_TO_AXI         = 4'd2,
      OP_AXI_TO_WB         = 4'd3,
      OP_UB_TO_DATA_FIFO   = 4'd4,
      OP_WB_TO_WEIGHT_FIFO = 4'd5,
      OP_MAT_MUL           = 4'd6,
      OP_MAT_MUL_ACC       = 4'd7,
      OP_ACC_TO_UB         = 4'd8
   } opcode_e;

   typedef enum logic [2:0] {
      ST_SETUP,
      ST_SAMPLE,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_FLAG_HI
   } disp_state_e;

   // everything above the last defined opcode is illegal
   function automatic logic op_is_legal(input int unsigned code);
      return code <= int'(OP_ACC_TO_UB);
   endfunction

endpackage

// File: rtl/inst_dispatcher.sv
// Instruction dispatcher: paces the instruction stream with a flag strobe,
// samples one instruction per flag period, hands non-IDLE instructions to the
// execution engines through a valid/ready handshake and waits for their
// single-cycle done pulse before strobing flag again.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   instruction  {opcode, addra, addrb}
//   flag         instruction-boundary strobe (high FLAG_CYCLES cycles)
//   idle_flag    high unless the last sampled instruction was a legal non-IDLE op
//   op_valid     dispatch request; held until op_ready
//   op_ready     engine accepts the dispatch
//   op_code/op_addra/op_addrb  fields latched at sampling
//   op_done      completion pulse, only honoured while waiting for it
//   illegal_op   sticky illegal-opcode indicator
//   inst_count   completed-instruction count, wraps at 16 bits
//
// state      | meaning
// -----------+-------------------------------------------------------------
// SETUP      | flag low, counting SETUP_CYCLES before sampling
// SAMPLE     | latch instruction fields; IDLE/illegal skip straight to flag
// ISSUE      | op_valid high with stable fields until op_ready
// WAIT_DONE  | dispatch accepted, waiting for op_done
// FLAG_HI    | flag high for FLAG_CYCLES cycles, then back to SETUP
module inst_dispatcher
   import inst_dispatcher_pkg::*;
#(
   parameter int OPCODE_BITS  = inst_dispatcher_pkg::OPCODE_BITS,
   parameter int ADDR_BITS    = inst_dispatcher_pkg::ADDR_BITS,
   parameter int SETUP_CYCLES = 2,
   parameter int FLAG_CYCLES  = 2
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [OPCODE_BITS+2*ADDR_BITS-1:0] instruction,
   output logic                             flag,
   output logic                             idle_flag,
   output logic                             op_valid,
   input  logic                             op_ready,
   output logic [OPCODE_BITS-1:0]           op_code,
   output logic [ADDR_BITS-1:0]             op_addra,
   output logic [ADDR_BITS-1:0]             op_addrb,
   input  logic                             op_done,
   output logic                             illegal_op,
   output logic [15:0]                      inst_count
);

   localparam int INST_W  = OPCODE_BITS + 2*ADDR_BITS;
   localparam int CNT_MAX = (SETUP_CYCLES > FLAG_CYCLES) ? SETUP_CYCLES : FLAG_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   // counter runs from 0 and the phase ends on its terminal count
   localparam logic [CNT_W-1:0] SETUP_TC = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLAG_TC  = CNT_W'(FLAG_CYCLES - 1);

   disp_state_e            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   latch_inst;
   logic                   enter_flag;

   logic [OPCODE_BITS-1:0] inst_op;
   logic [ADDR_BITS-1:0]   inst_addra;
   logic [ADDR_BITS-1:0]   inst_addrb;
   logic                   inst_legal;
   logic                   inst_exec;

   assign inst_op    = instruction[INST_W-1 -: OPCODE_BITS];
   assign inst_addra = instruction[2*ADDR_BITS-1 -: ADDR_BITS];
   assign inst_addrb = instruction[ADDR_BITS-1:0];
   assign inst_legal = op_is_legal(32'(inst_op));
   assign inst_exec  = inst_legal && (inst_op != '0);

   // decoded from the state register so reset drops them asynchronously
   assign flag     = (state_q == ST_FLAG_HI);
   assign op_valid = (state_q == ST_ISSUE);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      latch_inst = 1'b0;
      enter_flag = 1'b0;
      case (state_q)
         ST_SETUP: begin
            if (cnt_q == SETUP_TC) begin
               state_d = ST_SAMPLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_SAMPLE: begin
            latch_inst = 1'b1;
            if (inst_exec) begin
               state_d = ST_ISSUE;
            end else begin
               state_d    = ST_FLAG_HI;
               enter_flag = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (op_ready) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (op_done) begin
               state_d    = ST_FLAG_HI;
               enter_flag = 1'b1;
            end
         end
         ST_FLAG_HI: begin
            if (cnt_q == FLAG_TC) begin
               state_d = ST_SETUP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_SETUP;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_SETUP;
         cnt_q      <= '0;
         op_code    <= '0;
         op_addra   <= '0;
         op_addrb   <= '0;
         idle_flag  <= 1'b1;
         illegal_op <= 1'b0;
         inst_count <= 16'h0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch_inst) begin
            op_code   <= inst_op;
            op_addra  <= inst_addra;
            op_addrb  <= inst_addrb;
            idle_flag <= !inst_exec;
            if (!inst_legal) illegal_op <= 1'b1;
         end
         if (enter_flag) inst_count <= inst_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_inst_dispatcher.sv
module tb_inst_dispatcher;
   localparam int SETUP = 2;
   localparam int FLAGC = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [35:0] instruction;
   logic        flag, idle_flag, op_valid, op_ready, op_done, illegal_op;
   logic [3:0]  op_code;
   logic [15:0] op_addra, op_addrb, inst_count;

   int checks = 0;
   int errors = 0;

   inst_dispatcher #(.OPCODE_BITS(4), .ADDR_BITS(16), .SETUP_CYCLES(SETUP), .FLAG_CYCLES(FLAGC)) dut (
      .clk(clk), .reset_n(reset_n), .instruction(instruction),
      .flag(flag), .idle_flag(idle_flag), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_addra(op_addra), .op_addrb(op_addrb),
      .op_done(op_done), .illegal_op(illegal_op), .inst_count(inst_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each instruction period: wait SETUP+1 edges, sample; IDLE/illegal go straight
   // to the flag; others wait for the handshake and then the done pulse.
   localparam int P_PRE = 0, P_HS = 1, P_DONE = 2, P_FLAG = 3;
   int          m_phase = P_PRE;
   int          m_left  = SETUP + 1;
   logic [3:0]  m_code  = '0;
   logic [15:0] m_a = '0, m_b = '0, m_count = '0;
   logic        m_idle = 1'b1, m_illegal = 1'b0;
   int          preload_seq = 0;
   int          preload_seen = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase = P_PRE; m_left = SETUP + 1;
         m_code = '0; m_a = '0; m_b = '0; m_count = '0;
         m_idle = 1'b1; m_illegal = 1'b0;
      end else begin
         if (preload_seq != preload_seen) begin
            m_count = 16'hFFFF;
            preload_seen = preload_seq;
         end
         case (m_phase)
            P_PRE: begin
               m_left--;
               if (m_left == 0) begin
                  m_code = instruction[35:32];
                  m_a    = instruction[31:16];
                  m_b    = instruction[15:0];
                  if (m_code == 4'd0 || m_code > 4'd8) begin
                     m_idle = 1'b1;
                     if (m_code > 4'd8) m_illegal = 1'b1;
                     m_phase = P_FLAG; m_left = FLAGC; m_count++;
                  end else begin
                     m_idle = 1'b0;
                     m_phase = P_HS;
                  end
               end
            end
            P_HS:   if (op_ready) m_phase = P_DONE;
            P_DONE: if (op_done) begin m_phase = P_FLAG; m_left = FLAGC; m_count++; end
            default: begin
               m_left--;
               if (m_left == 0) begin m_phase = P_PRE; m_left = SETUP + 1; end
            end
         endcase
      end
   end

   int valid_run = 0;
   int last_valid_run = 0;

   always @(posedge clk) begin
      #1;
      check("flag",       32'(flag),       32'(m_phase == P_FLAG));
      check("op_valid",   32'(op_valid),   32'(m_phase == P_HS));
      check("idle_flag",  32'(idle_flag),  32'(m_idle));
      check("illegal_op", 32'(illegal_op), 32'(m_illegal));
      check("op_code",    32'(op_code),    32'(m_code));
      check("op_addra",   32'(op_addra),   32'(m_a));
      check("op_addrb",   32'(op_addrb),   32'(m_b));
      check("inst_count", 32'(inst_count), 32'(m_count));
      if (op_valid) valid_run++;
      else if (valid_run != 0) begin
         last_valid_run = valid_run;
         valid_run = 0;
      end
   end

   // ---------------- bounded waits ----------------
   task automatic wait_flag(input logic v);
      bit ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #2;
         if (flag === v) begin ok = 1'b1; break; end
      end
      if (!ok) check("wait_flag_timeout", 32'(flag), 32'(v));
   endtask

   task automatic wait_valid();
      bit ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #2;
         if (op_valid === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) check("wait_valid_timeout", 32'(op_valid), 32'd1);
   endtask

   task automatic edges_to_flag(input string nm, input int exp_edges);
      int n = 0;
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #2;
         n++;
         if (flag === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) check({nm, "_timeout"}, 32'(flag), 32'd1);
      else     check(nm, 32'(n), 32'(exp_edges));
   endtask

   initial begin
      reset_n = 1'b0; instruction = '0; op_ready = 1'b0; op_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_flag",   32'(flag),       32'd0);
      check("rst_idle",   32'(idle_flag),  32'd1);
      check("rst_valid",  32'(op_valid),   32'd0);
      check("rst_count",  32'(inst_count), 32'd0);
      check("rst_code",   32'(op_code),    32'd0);
      reset_n = 1'b1;

      // IDLE stream: rises 3 edges after release, 2 high, period 5
      repeat (2) @(posedge clk); #2;
      check("idle_pre_rise", 32'(flag), 32'd0);
      @(posedge clk); #2;
      check("idle_rise3",  32'(flag),       32'd1);
      check("idle_cnt1",   32'(inst_count), 32'd1);
      @(posedge clk); #2;
      check("idle_high2",  32'(flag), 32'd1);
      @(posedge clk); #2;
      check("idle_fall",   32'(flag), 32'd0);
      repeat (2) @(posedge clk); #2;
      check("idle_gap",    32'(flag), 32'd0);
      @(posedge clk); #2;
      check("idle_rise8",  32'(flag),       32'd1);
      check("idle_cnt2",   32'(inst_count), 32'd2);

      // opcode 1, ready low for 4 valid cycles, done pulse in ISSUE ignored
      @(negedge clk);
      instruction = {4'd1, 16'h0003, 16'h000C};
      wait_valid();
      check("op1_idle",  32'(idle_flag), 32'd0);
      check("op1_addra", 32'(op_addra),  32'h0003);
      check("op1_addrb", 32'(op_addrb),  32'h000C);
      @(negedge clk); op_done = 1'b1;
      @(negedge clk); op_done = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk); op_ready = 1'b1;
      @(posedge clk); #2;
      check("op1_valid_dropped", 32'(op_valid),       32'd0);
      check("op1_valid_len",     32'(last_valid_run), 32'd5);
      @(negedge clk); op_ready = 1'b0; instruction = '0;
      @(negedge clk);
      @(negedge clk);
      check("op1_flag_before_done", 32'(flag), 32'd0);
      op_done = 1'b1;
      @(posedge clk); #2;
      check("op1_flag_after_done", 32'(flag),       32'd1);
      check("op1_cnt",             32'(inst_count), 32'd3);
      @(negedge clk); op_done = 1'b0;

      // opcode 8 (last legal) with op_ready already high: one ISSUE cycle
      wait_flag(1'b0);
      @(negedge clk);
      instruction = {4'd8, 16'hABCD, 16'h1234}; op_ready = 1'b1;
      wait_valid();
      check("op8_code", 32'(op_code), 32'd8);
      @(posedge clk); #2;
      check("op8_valid_len", 32'(last_valid_run), 32'd1);
      check("op8_legal",     32'(illegal_op),     32'd0);
      @(negedge clk); op_ready = 1'b0; op_done = 1'b1;
      @(negedge clk); op_done = 1'b0;
      check("op8_flag", 32'(flag), 32'd1);

      // illegal opcode 0xC: sticky flag, IDLE timing
      wait_flag(1'b0);
      @(negedge clk);
      instruction = {4'hC, 16'h0001, 16'h0002};
      edges_to_flag("ill_edges_to_flag", SETUP + 1);
      check("ill_set", 32'(illegal_op), 32'd1);
      @(negedge clk); instruction = '0;
      wait_flag(1'b0);
      wait_flag(1'b1);
      check("ill_sticky", 32'(illegal_op), 32'd1);

      // reset while ISSUE holds op_valid
      wait_flag(1'b0);
      @(negedge clk);
      instruction = {4'd3, 16'h0055, 16'h00AA};
      wait_valid();
      @(negedge clk); reset_n = 1'b0;
      #1;
      check("rstiss_valid", 32'(op_valid),   32'd0);
      check("rstiss_idle",  32'(idle_flag),  32'd1);
      check("rstiss_ill",   32'(illegal_op), 32'd0);
      check("rstiss_count", 32'(inst_count), 32'd0);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1; op_ready = 1'b1;

      // reset during WAIT_DONE
      wait_valid();
      @(posedge clk); #2;
      check("rstwd_in_wait", 32'(op_valid), 32'd0);
      @(negedge clk); op_ready = 1'b0;
      @(negedge clk); reset_n = 1'b0;
      #1;
      check("rstwd_valid", 32'(op_valid),  32'd0);
      check("rstwd_flag",  32'(flag),      32'd0);
      check("rstwd_idle",  32'(idle_flag), 32'd1);
      @(negedge clk); reset_n = 1'b1; instruction = '0;
      edges_to_flag("rstwd_resume_edges", SETUP + 1);

      // wrap: preload 0xFFFF, next flag must show 0x0000
      wait_flag(1'b0);
      @(negedge clk);
      force dut.inst_count = 16'hFFFF;
      preload_seq++;
      #1 release dut.inst_count;
      wait_flag(1'b1);
      check("wrap_zero", 32'(inst_count), 32'h0000);
      wait_flag(1'b0);
      wait_flag(1'b1);
      check("wrap_one",  32'(inst_count), 32'h0001);

      repeat (3) @(posedge clk);
      #3;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0t required=finish", $time);
      $fatal(1);
   end
endmodule
